// File: rtl/sha3_axis_pkg.sv
// Constants, state type and byte-ordering helpers shared by the SHA3 AXI-Stream
// padder (receive side) and digest transmitter.
package sha3_axis_pkg;

    localparam int unsigned BEAT_BYTES       = 8;
    localparam int unsigned MAX_DIGEST_BYTES = 64;

    typedef enum logic {
        IDLE,
        SEND
    } tx_state_t;

    // Keccak lane order (byte 0 in [7:0]) to stream order (byte 0 in [63:56]).
    function automatic logic [63:0] bswap64(input logic [63:0] lane);
        logic [63:0] swapped;
        swapped = '0;
        for (int unsigned j = 0; j < BEAT_BYTES; j++) begin
            swapped[8*(BEAT_BYTES-1-j) +: 8] = lane[8*j +: 8];
        end
        return swapped;
    endfunction

    // Byte count (0..8) to an MSB-first byte-enable mask.
    function automatic logic [7:0] keep_from_count(input logic [3:0] count);
        logic [7:0] keep;
        keep = '0;
        for (int unsigned i = 0; i < BEAT_BYTES; i++) begin
            keep[BEAT_BYTES-1-i] = (4'(i) < count);
        end
        return keep;
    endfunction

endpackage

// File: rtl/axis_beat_select.sv
// Picks one 64-bit lane of the digest and turns it into a stream beat:
// byte swap, zero masking of unused bytes, TKEEP/TUSER/TLAST derivation.
module axis_beat_select
    import sha3_axis_pkg::*;
#(
    parameter int unsigned MAX_BYTES = MAX_DIGEST_BYTES
) (
    input  logic [8*MAX_BYTES-1:0] digest_i,
    input  logic [2:0]             beat_i,
    input  logic [6:0]             remaining_i,
    output logic [63:0]            tdata_c_o,
    output logic [7:0]             tkeep_c_o,
    output logic [5:0]             tuser_c_o,
    output logic                   tlast_c_o
);

    localparam int unsigned NBEATS = MAX_BYTES / BEAT_BYTES;

    logic [63:0] lane_c;
    logic [63:0] swapped_c;
    logic [3:0]  count_c;

    always_comb begin
        lane_c = '0;
        for (int unsigned i = 0; i < NBEATS; i++) begin
            if (beat_i == 3'(i)) begin
                lane_c = digest_i[64*i +: 64];
            end
        end
    end

    always_comb begin
        count_c   = (remaining_i >= 7'd8) ? 4'd8 : remaining_i[3:0];
        tkeep_c_o = keep_from_count(count_c);
        swapped_c = bswap64(lane_c);
        tdata_c_o = '0;
        // Bytes past the end of the digest are forced to zero.
        for (int unsigned b = 0; b < BEAT_BYTES; b++) begin
            tdata_c_o[8*b +: 8] = tkeep_c_o[b] ? swapped_c[8*b +: 8] : 8'h00;
        end
        tuser_c_o = 6'(count_c);
        tlast_c_o = (remaining_i <= 7'd8);
    end

endmodule

// File: rtl/sha3_digest_axis_tx.sv
// Captures one finished digest and streams it MSB-first as a 1..8 beat
// AXI4-Stream packet with registered outputs and TREADY backpressure.
module sha3_digest_axis_tx
    import sha3_axis_pkg::*;
#(
    parameter int unsigned MAX_BYTES = MAX_DIGEST_BYTES
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic [8*MAX_BYTES-1:0] digest,
    input  logic [6:0]             digest_len,
    input  logic                   digest_valid,
    output logic                   digest_ready,
    output logic [63:0]            M_AXIS_TDATA,
    output logic [7:0]             M_AXIS_TKEEP,
    output logic [5:0]             M_AXIS_TUSER,
    output logic                   M_AXIS_TLAST,
    output logic                   M_AXIS_TVALID,
    input  logic                   M_AXIS_TREADY
);

    localparam logic [6:0] MAX_LEN = 7'(MAX_BYTES);

    tx_state_t              state_q;
    logic [8*MAX_BYTES-1:0] digest_q;
    logic [6:0]             rem_q;
    logic [2:0]             beat_q;
    logic                   ready_q;
    logic                   tvalid_q;
    logic [63:0]            tdata_q;
    logic [7:0]             tkeep_q;
    logic [5:0]             tuser_q;
    logic                   tlast_q;

    logic [6:0]             len_c;
    logic                   accept_c;
    logic [8*MAX_BYTES-1:0] sel_digest_c;
    logic [2:0]             sel_beat_c;
    logic [6:0]             sel_rem_c;
    logic [63:0]            nxt_tdata_c;
    logic [7:0]             nxt_tkeep_c;
    logic [5:0]             nxt_tuser_c;
    logic                   nxt_tlast_c;

    // In IDLE the beat-0 view of the incoming digest is prepared so the first
    // beat is registered on the accept edge; in SEND the next stored beat is.
    always_comb begin
        len_c        = (digest_len == 7'd0 || digest_len > MAX_LEN) ? MAX_LEN : digest_len;
        accept_c     = (state_q == IDLE) && ready_q && digest_valid;
        sel_digest_c = (state_q == IDLE) ? digest : digest_q;
        sel_beat_c   = (state_q == IDLE) ? 3'd0 : beat_q + 3'd1;
        sel_rem_c    = (state_q == IDLE) ? len_c : rem_q - 7'd8;
    end

    axis_beat_select #(
        .MAX_BYTES (MAX_BYTES)
    ) u_beat_select (
        .digest_i    (sel_digest_c),
        .beat_i      (sel_beat_c),
        .remaining_i (sel_rem_c),
        .tdata_c_o   (nxt_tdata_c),
        .tkeep_c_o   (nxt_tkeep_c),
        .tuser_c_o   (nxt_tuser_c),
        .tlast_c_o   (nxt_tlast_c)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q  <= IDLE;
            digest_q <= '0;
            rem_q    <= '0;
            beat_q   <= '0;
            ready_q  <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tuser_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept_c) begin
                        digest_q <= digest;
                        rem_q    <= len_c;
                        beat_q   <= 3'd0;
                        ready_q  <= 1'b0;
                        tvalid_q <= 1'b1;
                        tdata_q  <= nxt_tdata_c;
                        tkeep_q  <= nxt_tkeep_c;
                        tuser_q  <= nxt_tuser_c;
                        tlast_q  <= nxt_tlast_c;
                        state_q  <= SEND;
                    end
                end
                SEND: begin
                    if (tvalid_q && M_AXIS_TREADY) begin
                        if (tlast_q) begin
                            state_q  <= IDLE;
                            ready_q  <= 1'b1;
                            tvalid_q <= 1'b0;
                            tdata_q  <= '0;
                            tkeep_q  <= '0;
                            tuser_q  <= '0;
                            tlast_q  <= 1'b0;
                        end else begin
                            beat_q  <= sel_beat_c;
                            rem_q   <= sel_rem_c;
                            tdata_q <= nxt_tdata_c;
                            tkeep_q <= nxt_tkeep_c;
                            tuser_q <= nxt_tuser_c;
                            tlast_q <= nxt_tlast_c;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign digest_ready  = ready_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TKEEP  = tkeep_q;
    assign M_AXIS_TUSER  = tuser_q;
    assign M_AXIS_TLAST  = tlast_q;

endmodule

// File: tb/tb_sha3_digest_axis_tx.sv
// Scoreboard bench for sha3_digest_axis_tx: stimulus pushes expected beats,
// a negedge monitor pops and compares on every handshake.
module tb_sha3_digest_axis_tx;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic [5:0]  user;
        logic        last;
    } beat_t;

    logic         ACLK;
    logic         ARESETn;
    logic [511:0] digest;
    logic [6:0]   digest_len;
    logic         digest_valid;
    logic         digest_ready;
    logic [63:0]  M_AXIS_TDATA;
    logic [7:0]   M_AXIS_TKEEP;
    logic [5:0]   M_AXIS_TUSER;
    logic         M_AXIS_TLAST;
    logic         M_AXIS_TVALID;
    logic         M_AXIS_TREADY;

    beat_t exp_q[$];
    int    n_cmp    = 0;
    int    n_err    = 0;
    int    rdy_mode = 0;   // 0: always ready, 1: random, 2: held low, 3: manual

    sha3_digest_axis_tx #(.MAX_BYTES(64)) dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .digest        (digest),
        .digest_len    (digest_len),
        .digest_valid  (digest_valid),
        .digest_ready  (digest_ready),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TKEEP  (M_AXIS_TKEEP),
        .M_AXIS_TUSER  (M_AXIS_TUSER),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] pat(input logic [7:0] base);
        logic [511:0] d;
        for (int j = 0; j < 64; j++) d[8*j +: 8] = base + 8'(j);
        return d;
    endfunction

    task automatic push(input logic [63:0] data, input logic [7:0] keep,
                        input logic [5:0] user, input logic last);
        beat_t b;
        b.data = data; b.keep = keep; b.user = user; b.last = last;
        exp_q.push_back(b);
    endtask

    // Reference: byte b of the packet lands in beat b/8 at MSB-first slot b%8.
    task automatic push_model(input logic [511:0] d, input int len);
        for (int k = 0; 8*k < len; k++) begin
            logic [63:0] data;
            logic [7:0]  keep;
            int          n;
            data = '0; keep = '0; n = 0;
            for (int p = 0; p < 8; p++) begin
                if (8*k + p < len) begin
                    data[63-8*p -: 8] = d[8*(8*k+p) +: 8];
                    keep[7-p] = 1'b1;
                    n++;
                end
            end
            push(data, keep, 6'(n), (8*k + 8 >= len));
        end
    endtask

    task automatic push_sha256();
        push(64'h0001020304050607, 8'hFF, 6'd8, 1'b0);
        push(64'h08090A0B0C0D0E0F, 8'hFF, 6'd8, 1'b0);
        push(64'h1011121314151617, 8'hFF, 6'd8, 1'b0);
        push(64'h18191A1B1C1D1E1F, 8'hFF, 6'd8, 1'b1);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic present(input logic [511:0] d, input logic [6:0] len);
        int t;
        t = 0;
        while (!digest_ready && t < 300) begin
            @(posedge ACLK); #1; t++;
        end
        if (!digest_ready) begin
            chk("ready_timeout", 64'(digest_ready), 64'd1);
            return;
        end
        digest = d; digest_len = len; digest_valid = 1'b1;
        @(posedge ACLK); #1;
        digest_valid = 1'b0;
        digest = '1;
        chk("first_beat_latency", 64'(M_AXIS_TVALID), 64'd1);
    endtask

    task automatic wait_done(input int exp_cycles);
        int c;
        c = 0;
        while (!digest_ready && c < 300) begin
            @(posedge ACLK); #1; c++;
        end
        if (!digest_ready) chk("done_timeout", 64'(digest_ready), 64'd1);
        else if (exp_cycles >= 0) chk("packet_cycles", 64'(c), 64'(exp_cycles));
    endtask

    always @(posedge ACLK) begin
        #1;
        case (rdy_mode)
            0: M_AXIS_TREADY = 1'b1;
            1: M_AXIS_TREADY = 1'($urandom_range(0, 1));
            2: M_AXIS_TREADY = 1'b0;
            default: ;
        endcase
    end

    // Monitor: handshake scoreboard, stall stability, ready after TLAST.
    beat_t prev_beat;
    logic  prev_stall   = 1'b0;
    logic  prev_last_hs = 1'b0;
    always @(negedge ACLK) begin
        beat_t cur;
        cur = {M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TUSER, M_AXIS_TLAST};
        if (!ARESETn) begin
            prev_stall   = 1'b0;
            prev_last_hs = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_tdata", cur.data, prev_beat.data);
                chk("stall_ctrl", 64'({M_AXIS_TVALID, cur.keep, cur.user, cur.last}),
                    64'({1'b1, prev_beat.keep, prev_beat.user, prev_beat.last}));
            end
            if (prev_last_hs) chk("ready_after_last", 64'(digest_ready), 64'd1);
            if (M_AXIS_TVALID) chk("ready_while_send", 64'(digest_ready), 64'd0);
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", cur.data, 64'd0);
                    chk("unexpected_beat_ctrl", 64'({cur.keep, cur.user, cur.last}), 64'd0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("tdata", cur.data, e.data);
                    chk("tkeep", 64'(cur.keep), 64'(e.keep));
                    chk("tuser", 64'(cur.user), 64'(e.user));
                    chk("tlast", 64'(cur.last), 64'(e.last));
                end
            end
            prev_stall   = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_last_hs = M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST;
            prev_beat    = cur;
        end
    end

    task automatic chk_all_zero(input string name);
        chk({name, "_tdata"}, M_AXIS_TDATA, 64'd0);
        chk({name, "_ctrl"}, 64'({M_AXIS_TKEEP, M_AXIS_TUSER, M_AXIS_TLAST,
                                  M_AXIS_TVALID, digest_ready}), 64'd0);
    endtask

    initial begin
        ARESETn = 1'b0; digest = '0; digest_len = '0; digest_valid = 1'b0;
        M_AXIS_TREADY = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        chk_all_zero("reset");
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        chk("ready_after_reset", 64'(digest_ready), 64'd1);

        // SHA3-256, full-rate
        push_sha256();
        present(pat(8'h00), 7'd32);
        wait_done(4);

        // Partial last beat
        push(64'h0001020304050607, 8'hFF, 6'd8, 1'b0);
        push(64'h08090A0B0C0D0E0F, 8'hFF, 6'd8, 1'b0);
        push(64'h1011121300000000, 8'hF0, 6'd4, 1'b1);
        present(pat(8'h00), 7'd20);
        wait_done(3);

        // Length edge cases
        push_model(pat(8'h40), 64);
        present(pat(8'h40), 7'd0);
        wait_done(8);
        push_model(pat(8'h40), 64);
        present(pat(8'h40), 7'd100);
        wait_done(8);
        push_model(pat(8'h40), 64);
        present(pat(8'h40), 7'd64);
        wait_done(8);
        push(64'hA500000000000000, 8'h80, 6'd1, 1'b1);
        present(pat(8'hA5), 7'd1);
        wait_done(1);

        // Random backpressure
        rdy_mode = 1;
        push_sha256();
        present(pat(8'h00), 7'd32);
        wait_done(-1);
        push_model(pat(8'h33), 44);
        present(pat(8'h33), 7'd44);
        wait_done(-1);

        // Second digest offered while busy is ignored
        rdy_mode = 2;
        @(posedge ACLK); #1;
        push_model(pat(8'h10), 16);
        present(pat(8'h10), 7'd16);
        digest = pat(8'h80); digest_len = 7'd8; digest_valid = 1'b1;
        @(posedge ACLK); #1;
        digest_valid = 1'b0;
        chk("busy_ready", 64'(digest_ready), 64'd0);
        rdy_mode = 0;
        wait_done(-1);
        push(64'h8081828384858687, 8'hFF, 6'd8, 1'b1);
        present(pat(8'h80), 7'd8);
        wait_done(1);

        // Reset during beat 2 of 4
        rdy_mode = 3;
        @(posedge ACLK); #1;
        M_AXIS_TREADY = 1'b0;
        push(64'h0001020304050607, 8'hFF, 6'd8, 1'b0);
        push(64'h08090A0B0C0D0E0F, 8'hFF, 6'd8, 1'b0);
        present(pat(8'h00), 7'd32);
        M_AXIS_TREADY = 1'b1;
        repeat (2) begin
            @(posedge ACLK); #1;
        end
        M_AXIS_TREADY = 1'b0;
        ARESETn = 1'b0;
        @(posedge ACLK); #1;
        chk_all_zero("midpkt_reset");
        chk("midpkt_queue", 64'(exp_q.size()), 64'd0);
        ARESETn = 1'b1;
        rdy_mode = 0;
        M_AXIS_TREADY = 1'b1;
        @(posedge ACLK); #1;
        chk("ready_after_midpkt_reset", 64'(digest_ready), 64'd1);
        push_sha256();
        present(pat(8'h00), 7'd32);
        wait_done(4);

        repeat (5) @(posedge ACLK);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
